// File: rtl/mem_share_ctrl.sv
// Shared single-port register memory: self-initialises mem[i] = i after reset,
// then serves two requesters round-robin at one access per cycle.

module mem_share_rport #(
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // rdata only moves on a granted read, so it holds between reads
    always_comb begin
        rvalid_d = rd_en;
        rdata_d  = rd_en ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

module mem_share_ctrl #(
    parameter int AW    = 3,
    parameter int DEPTH = 8,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    output logic          init_done
);

    typedef enum logic {INIT, SERVE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;          // 0 = A has priority, 1 = B
    logic          init_done_q, init_done_d;

    logic [DW-1:0] mem_q [DEPTH];

    // index 0 = requester A, index 1 = requester B
    logic [1:0]           req, we, gnt, rd_en, rvalid;
    logic [1:0][AW-1:0]   addr;
    logic [1:0][DW-1:0]   wdata, rdata;
    logic                 sel;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    assign req   = {req_b, req_a};
    assign we    = {we_b, we_a};
    assign addr  = {addr_b, addr_a};
    assign wdata = {wdata_b, wdata_a};

    always_comb begin
        gnt = '0;
        if (state_q == SERVE) begin
            if (req[0] && (!req[1] || !ptr_q))
                gnt[0] = 1'b1;
            else if (req[1])
                gnt[1] = 1'b1;
        end
    end

    assign sel   = gnt[1];
    assign rd_en = gnt & ~we;

    // INIT owns the write port; in SERVE only a granted write reaches it
    always_comb begin
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = DW'(cnt_q);
        end else begin
            mem_we    = |gnt && we[sel];
            mem_waddr = addr[sel];
            mem_wdata = wdata[sel];
        end
    end

    assign mem_rdata = mem_q[addr[sel]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}})
                    state_d = SERVE;
            end
            default: begin
                if (gnt[0])
                    ptr_d = 1'b1;
                else if (gnt[1])
                    ptr_d = 1'b0;
            end
        endcase
        init_done_d = (state_d == SERVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
        end
    end

    // storage is deliberately unreset; INIT rewrites every entry
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    for (genvar i = 0; i < 2; i++) begin : g_rport
        mem_share_rport #(.DW(DW)) u_rport (
            .clk       (clk),
            .rst       (rst),
            .rd_en     (rd_en[i]),
            .mem_rdata (mem_rdata),
            .rvalid    (rvalid[i]),
            .rdata     (rdata[i])
        );
    end

    assign gnt_a     = gnt[0];
    assign gnt_b     = gnt[1];
    assign rvalid_a  = rvalid[0];
    assign rvalid_b  = rvalid[1];
    assign rdata_a   = rdata[0];
    assign rdata_b   = rdata[1];
    assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_share_ctrl.sv
// Directed bench for mem_share_ctrl: init sequencing, arbitration, RAW and reset.

module tb_mem_share_ctrl;

    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
    logic [DW-1:0] rdata_a, rdata_b;

    int n_total = 0;
    int n_pass  = 0;

    mem_share_ctrl #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // advance one clock; sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // single A read; checks grant, the rvalid pulse, then rvalid low with rdata held
    task automatic read_a(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req_a = 1'b1; we_a = 1'b0; addr_a = a;
        #1 chk("rd_a_gnt", 32'(gnt_a), 32'd1);
        tick();
        req_a = 1'b0;
        chk("rd_a_rvalid", 32'(rvalid_a), 32'd1);
        chk("rd_a_rdata", 32'(rdata_a), 32'(exp));
        tick();
        chk("rd_a_rvalid_low", 32'(rvalid_a), 32'd0);
        chk("rd_a_rdata_hold", 32'(rdata_a), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        tick(); tick();

        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("rst_rdata_a", 32'(rdata_a), 32'd0);
        chk("rst_rdata_b", 32'(rdata_b), 32'd0);

        // A holds a read of addr 5 across the whole INIT window
        req_a = 1'b1; addr_a = 3'd5;
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            chk("init_done_low", 32'(init_done), 32'd0);
            chk("init_gnt_a_low", 32'(gnt_a), 32'd0);
            tick();
        end
        #1;
        chk("init_done_high", 32'(init_done), 32'd1);
        chk("held_req_gnt_a", 32'(gnt_a), 32'd1);
        tick();
        req_a = 1'b0;
        chk("held_req_rvalid", 32'(rvalid_a), 32'd1);
        chk("held_req_rdata", 32'(rdata_a), 32'd5);
        tick();

        for (int i = 0; i < DEPTH; i++) read_a(AW'(i), DW'(i));

        // A won last, so pointer = B; one B grant returns priority to A
        req_b = 1'b1; addr_b = 3'd7;
        #1 chk("b_single_gnt", 32'(gnt_b), 32'd1);
        tick();
        req_b = 1'b0;
        chk("b_single_rvalid", 32'(rvalid_b), 32'd1);
        chk("b_single_rdata", 32'(rdata_b), 32'd7);
        tick();

        // contention: expect A, B, A, B
        req_a = 1'b1; addr_a = 3'd1; req_b = 1'b1; addr_b = 3'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_gnt_a", 32'(gnt_a), 32'((k % 2) == 0));
            chk("rr_gnt_b", 32'(gnt_b), 32'((k % 2) == 1));
            chk("rr_mutex", 32'(gnt_a & gnt_b), 32'd0);
            tick();
            chk("rr_rvalid_a", 32'(rvalid_a), 32'((k % 2) == 0));
            chk("rr_rvalid_b", 32'(rvalid_b), 32'((k % 2) == 1));
            if ((k % 2) == 0) chk("rr_rdata_a", 32'(rdata_a), 32'd1);
            else              chk("rr_rdata_b", 32'(rdata_b), 32'd2);
        end
        req_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("solo_gnt_a", 32'(gnt_a), 32'd1);
            chk("solo_gnt_b", 32'(gnt_b), 32'd0);
            tick();
        end
        req_a = 1'b0;
        tick();

        // read-after-write: A writes 6 to addr 3, B reads it next cycle
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 3'd6;
        #1 chk("raw_wr_gnt_a", 32'(gnt_a), 32'd1);
        tick();
        req_a = 1'b0; we_a = 1'b0;
        chk("raw_wr_no_rvalid", 32'(rvalid_a), 32'd0);
        req_b = 1'b1; addr_b = 3'd3;
        #1 chk("raw_rd_gnt_b", 32'(gnt_b), 32'd1);
        tick();
        chk("raw_rvalid_b", 32'(rvalid_b), 32'd1);
        chk("raw_rdata_b", 32'(rdata_b), 32'd6);
        addr_b = 3'd4;
        tick();
        req_b = 1'b0;
        chk("neighbor_rvalid_b", 32'(rvalid_b), 32'd1);
        chk("neighbor_rdata_b", 32'(rdata_b), 32'd4);
        tick();

        // reset in the 4th INIT cycle restarts the sequencer
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1 chk("midinit_rst_done", 32'(init_done), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            #1 chk("reinit_done_low", 32'(init_done), 32'd0);
            tick();
        end
        #1 chk("reinit_done_high", 32'(init_done), 32'd1);
        // INIT rewrote addr 3 back to 3
        for (int i = 0; i < DEPTH; i++) read_a(AW'(i), DW'(i));

        // reset right after a granted read cancels the rvalid
        req_a = 1'b1; addr_a = 3'd6;
        tick();
        req_a = 1'b0;
        chk("pre_rst_rvalid", 32'(rvalid_a), 32'd1);
        rst = 1'b1;
        #1;
        chk("in_rst_rvalid", 32'(rvalid_a), 32'd0);
        chk("in_rst_rdata", 32'(rdata_a), 32'd0);
        tick();
        chk("in_rst_rvalid2", 32'(rvalid_a), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            tick();
            chk("post_rst_rvalid_a", 32'(rvalid_a), 32'd0);
            chk("post_rst_rvalid_b", 32'(rvalid_b), 32'd0);
        end
        chk("post_rst_done", 32'(init_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
